// File: rtl/seq_restoring_div.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional two's-complement mode, divide-by-zero and overflow flags.
module seq_restoring_div #(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] q;
   logic [WIDTH:0]   m;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] raw;
   logic             sd;
   logic             sv;
   logic             dz;
   logic             ovf_p;

   logic             smode;
   logic             dd_neg;
   logic             dv_neg;
   logic [WIDTH-1:0] dd_mag;
   logic [WIDTH-1:0] dv_mag;
   logic [WIDTH-1:0] min_neg;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   always_comb begin
      smode   = signed_mode & SIGNED_EN;
      dd_neg  = smode & dividend[WIDTH-1];
      dv_neg  = smode & divisor[WIDTH-1];
      dd_mag  = dd_neg ? (~dividend + 1'b1) : dividend;
      dv_mag  = dv_neg ? (~divisor + 1'b1) : divisor;
      min_neg = {1'b1, {(WIDTH-1){1'b0}}};
      shifted = {a, q[WIDTH-1]};
      diff    = shifted - m;
      q_fix   = (sd ^ sv) ? (~q + 1'b1) : q;
      r_fix   = sd ? (~a + 1'b1) : a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         cnt         <= '0;
         raw         <= '0;
         sd          <= 1'b0;
         sv          <= 1'b0;
         dz          <= 1'b0;
         ovf_p       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  sd    <= dd_neg;
                  sv    <= dv_neg;
                  raw   <= dividend;
                  dz    <= (divisor == '0);
                  ovf_p <= smode && (dividend == min_neg) &&
                           (divisor == '1);
                  q     <= dd_mag;
                  m     <= {1'b0, dv_mag};
                  a     <= '0;
                  cnt   <= '0;
                  state <= (divisor == '0) ? FIX : RUN;
               end
            end
            RUN: begin
               // diff[WIDTH] set means the trial subtraction went negative
               if (diff[WIDTH]) begin
                  a <= shifted[WIDTH-1:0];
                  q <= {q[WIDTH-2:0], 1'b0};
               end else begin
                  a <= diff[WIDTH-1:0];
                  q <= {q[WIDTH-2:0], 1'b1};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
               if (dz) begin
                  quotient    <= '1;
                  remainder   <= raw;
                  div_by_zero <= 1'b1;
                  overflow    <= 1'b0;
               end else begin
                  quotient    <= q_fix;
                  remainder   <= r_fix;
                  div_by_zero <= 1'b0;
                  overflow    <= ovf_p;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
